// File: rtl/instr_encode_loader.sv
// Boot/test loader: packs R/I/J field tuples into 32-bit MIPS-style words and writes them
// sequentially into instruction memory through a registered write port.
module instr_encode_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_start,
  input  logic              in_done,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [31:0]       in_imm,
  input  logic              in_sext,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic [ADDR_W:0]   out_count,
  output logic              out_full,
  output logic              out_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  localparam logic [ADDR_W:0] DepthC = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] OneC   = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                err_q, err_d;

  logic [31:0]         word_enc;
  logic                legal;
  logic                accept;

  // Encoding and range check follow the decoder's extender mode for I-type immediates.
  always_comb begin
    word_enc = 32'b0;
    legal    = 1'b0;
    unique case (in_fmt)
      2'd0: begin
        word_enc = {in_op, in_rs, in_rt, in_rd, in_shamt, in_funct};
        legal    = 1'b1;
      end
      2'd1: begin
        word_enc = {in_op, in_rs, in_rt, in_imm[15:0]};
        legal    = in_sext ? ((&in_imm[31:15]) | ~(|in_imm[31:15])) : ~(|in_imm[31:16]);
      end
      2'd2: begin
        word_enc = {in_op, in_imm[25:0]};
        legal    = ~(|in_imm[31:26]);
      end
      default: begin
        word_enc = 32'b0;
        legal    = 1'b0;
      end
    endcase
  end

  assign out_ready = (state_q == StLoad) & ~in_start & ~in_done;
  assign accept    = in_valid & out_ready;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    word_d  = word_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    if (in_start) begin
      state_d = StLoad;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else if (in_done) begin
      state_d = StIdle;
    end else if (accept) begin
      if (legal) begin
        we_d    = 1'b1;
        // count_q < DEPTH <= 2**ADDR_W while loading, so the truncation is lossless.
        addr_d  = count_q[ADDR_W-1:0];
        word_d  = word_enc;
        count_d = count_q + OneC;
        if (count_d == DepthC) begin
          full_d  = 1'b1;
          state_d = StFull;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      word_q  <= 32'b0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign out_we    = we_q;
  assign out_addr  = addr_q;
  assign out_word  = word_q;
  assign out_count = count_q;
  assign out_full  = full_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: directed spec vectors followed by randomized sessions, all
// checked against an arithmetic reference model of the loader.
module tb_instr_encode_loader;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, done = 1'b0, valid = 1'b0, sext = 1'b0;
  logic [1:0]    fmt = 2'd0;
  logic [5:0]    op = '0, funct = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [31:0]   imm = '0;
  logic          ready, we, full, err;
  logic [AW-1:0] addr;
  logic [31:0]   word;
  logic [AW:0]   count;

  instr_encode_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .in_done(done), .in_valid(valid),
    .out_ready(ready), .in_fmt(fmt), .in_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd),
    .in_shamt(shamt), .in_funct(funct), .in_imm(imm), .in_sext(sext), .out_we(we),
    .out_addr(addr), .out_word(word), .out_count(count), .out_full(full), .out_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 loading, 2 full
  int          m_state = 0;
  int          m_count = 0;
  int          m_addr  = 0;
  bit          m_err   = 0;
  bit          m_we    = 0;
  logic [31:0] m_word  = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word();
    longint unsigned w;
    longint unsigned u = longint'(imm);
    case (fmt)
      2'd0: w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048
                + shamt * 64'd64 + funct;
      2'd1: w = op * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + (u % 64'd65536);
      default: w = op * 64'd67108864 + (u % 64'd67108864);
    endcase
    return w[31:0];
  endfunction

  function automatic bit ref_legal();
    int si = int'(imm);
    longint unsigned u = longint'(imm);
    case (fmt)
      2'd0: return 1'b1;
      2'd1: return sext ? (si >= -32768 && si <= 32767) : (u < 64'd65536);
      2'd2: return u < 64'd67108864;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outputs(string pfx);
    chk({pfx, "_we"}, 32'(we), 32'(m_we));
    chk({pfx, "_addr"}, 32'(addr), 32'(m_addr));
    chk({pfx, "_word"}, word, m_word);
    chk({pfx, "_count"}, 32'(count), 32'(m_count));
    chk({pfx, "_full"}, 32'(full), 32'(m_count == DEPTH));
    chk({pfx, "_err"}, 32'(err), 32'(m_err));
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next one.
  task automatic cyc(string pfx);
    bit rdy;
    #1;
    rdy = (m_state == 1) && !start && !done;
    chk({pfx, "_ready"}, 32'(ready), 32'(rdy));
    m_we = 0;
    if (start) begin
      m_state = 1; m_count = 0; m_err = 0;
    end else if (done) begin
      m_state = 0;
    end else if (valid && rdy) begin
      if (ref_legal()) begin
        m_we = 1; m_addr = m_count; m_word = ref_word(); m_count++;
        if (m_count == DEPTH) m_state = 2;
      end else begin
        m_err = 1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(pfx);
    @(negedge clk);
  endtask

  task automatic set_tuple(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                           input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                           input logic [5:0] fn, input logic [31:0] im, input logic sx);
    valid = 1'b1; fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
    imm = im; sext = sx;
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_addr = 0; m_err = 0; m_we = 0; m_word = '0;
  endtask

  initial begin
    #1;
    check_outputs("rst");
    chk("rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start = 1'b1; cyc("start"); start = 1'b0;

    set_tuple(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'd0, 1'b0);
    cyc("r");
    chk("r_vec_word", word, 32'h00221820);
    chk("r_vec_addr", 32'(addr), 32'd0);

    set_tuple(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'hFFFFFFFC, 1'b1);
    cyc("i");
    chk("i_vec_word", word, 32'h2022FFFC);
    chk("i_vec_count", 32'(count), 32'd2);

    set_tuple(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h00000100, 1'b0);
    cyc("j");
    chk("j_vec_word", word, 32'h08000100);

    set_tuple(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h00018000, 1'b0);
    cyc("rej");
    chk("rej_vec_we", 32'(we), 32'd0);
    chk("rej_vec_err", 32'(err), 32'd1);

    set_tuple(2'd3, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'd0, 1'b0);
    cyc("illegal");
    valid = 1'b0; cyc("idle");

    set_tuple(2'd0, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 32'd0, 1'b0);
    cyc("last");
    chk("full_vec", 32'(full), 32'd1);
    cyc("over");
    chk("over_vec_we", 32'(we), 32'd0);

    // Start beats a simultaneous valid tuple.
    start = 1'b1; cyc("restart"); start = 1'b0;
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_err", 32'(err), 32'd0);

    for (int i = 0; i < 5; i++) begin
      set_tuple(2'd2, 6'(i + 1), 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'(i * 4), 1'b0);
      cyc("b2b");
    end
    valid = 1'b0;
    done = 1'b1; cyc("done"); done = 1'b0;
    cyc("post_done");

    // Reset arriving while a tuple is being accepted must suppress the write.
    start = 1'b1; cyc("rs_start"); start = 1'b0;
    set_tuple(2'd0, 6'd1, 5'd2, 5'd3, 5'd4, 5'd5, 6'd6, 32'd0, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    chk("async_rst_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
    cyc("after_rst");

    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 19) == 0) || (m_state != 1 && $urandom_range(0, 3) == 0);
      done  = ($urandom_range(0, 29) == 0);
      valid = ($urandom_range(0, 9) < 7);
      fmt   = 2'($urandom_range(0, 3));
      op    = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      shamt = 5'($urandom); funct = 6'($urandom); sext = 1'($urandom);
      case ($urandom_range(0, 3))
        0: imm = 32'(int'($urandom_range(0, 80000)) - 40000);
        1: imm = $urandom;
        2: imm = $urandom & 32'h07FFFFFF;
        default: imm = $urandom & 32'h0000FFFF;
      endcase
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
